tpg_cfg_sequencer: RTL and testbench

- Hardware AXI4-Lite write master that configures and launches the video Test Pattern Generator after reset, replacing the simulation-only VIP register sequence.
- Latches frame height/width, background pattern and colour format on a start pulse.
- Issues the five TPG register writes in fixed order, then reports done or error.
- Sits between the system control logic and the TPG s_axi_CTRL port, in the 40 MHz control domain.

---
 rtl/tpg_cfg_sequencer_pkg.sv | 64 ++++++
 rtl/tpg_cfg_sequencer_if.sv | 31 +++
 rtl/tpg_cfg_sequencer_axil_single_write.sv | 98 +++++++++
 rtl/tpg_cfg_sequencer.sv | 177 +++++++++++++++++
 tb/tb_tpg_cfg_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tpg_cfg_sequencer_pkg.sv
// Shared definitions for the TPG configuration sequencer: register map, FSM states, error codes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tpg_cfg_pkg;

    localparam int AXI_AW = 12;
    localparam int AXI_DW = 32;

    // TPG s_axi_CTRL register offsets
    localparam logic [AXI_AW-1:0] REG_CTRL         = 12'h000;
    localparam logic [AXI_AW-1:0] REG_HEIGHT       = 12'h010;
    localparam logic [AXI_AW-1:0] REG_WIDTH        = 12'h018;
    localparam logic [AXI_AW-1:0] REG_BG_PATTERN   = 12'h020;
    localparam logic [AXI_AW-1:0] REG_COLOR_FORMAT = 12'h040;

    // ap_start | auto_restart
    localparam logic [AXI_DW-1:0] CTRL_START_AUTORESTART = 32'h0000_0081;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_ISSUE,
        ST_WAIT_B,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_RESP    = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_e;

    typedef struct packed {
        logic [15:0] height;
        logic [15:0] width;
        logic [7:0]  pattern;
        logic [7:0]  format;
    } cfg_t;

    // Register offset of write number idx in the launch sequence.
    function automatic logic [AXI_AW-1:0] wr_offset(input logic [2:0] idx);
        case (idx)
            3'd0:    return REG_HEIGHT;
            3'd1:    return REG_WIDTH;
            3'd2:    return REG_BG_PATTERN;
            3'd3:    return REG_COLOR_FORMAT;
            default: return REG_CTRL;
        endcase
    endfunction

    // Data of write number idx, fields zero-extended to the bus width.
    function automatic logic [AXI_DW-1:0] wr_data(input logic [2:0] idx, input cfg_t cfg);
        case (idx)
            3'd0:    return {16'h0, cfg.height};
            3'd1:    return {16'h0, cfg.width};
            3'd2:    return {24'h0, cfg.pattern};
            3'd3:    return {24'h0, cfg.format};
            default: return CTRL_START_AUTORESTART;
        endcase
    endfunction

endpackage

// File: rtl/tpg_cfg_sequencer_if.sv
// AXI4-Lite write-only bundle (AW, W, B) between the sequencer and the TPG control port.
// Latency: n/a (wires only).
// Backpressure: standard AXI valid/ready on each channel.
// master: drives awaddr/awprot/awvalid, wdata/wstrb/wvalid, bready.
// slave : drives awready, wready, bresp/bvalid.
interface tpg_cfg_sequencer_if;
    import tpg_cfg_pkg::*;

    logic [AXI_AW-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [AXI_DW-1:0] wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/tpg_cfg_sequencer_axil_single_write.sv
// One AXI4-Lite write (AW+W then B) per req pulse, aborted after TIMEOUT cycles without a response.
// Latency: valids rise the cycle after req; ack is the cycle of the B handshake (2 cycles minimum).
// Backpressure: AW/W held stable until each own ready; bready held until bvalid; abort drops all.
// Ports: aclk/aresetn; req+addr+data in; issued (AW and W both done), ack+resp, timeout out;
//        m_axi master modport.
module axil_single_write
    import tpg_cfg_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              req,
    input  logic [AXI_AW-1:0] addr,
    input  logic [AXI_DW-1:0] data,
    output logic              issued,
    output logic              ack,
    output logic [1:0]        resp,
    output logic              timeout,
    tpg_cfg_sequencer_if.master m_axi
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    logic              aw_pend_q, aw_pend_d;
    logic              w_pend_q,  w_pend_d;
    logic              b_wait_q,  b_wait_d;
    logic [AXI_AW-1:0] addr_q,    addr_d;
    logic [AXI_DW-1:0] data_q,    data_d;
    logic [CW-1:0]     cnt_q,     cnt_d;
    logic              active;

    always_comb begin
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        b_wait_d  = b_wait_q;
        addr_d    = addr_q;
        data_d    = data_q;
        cnt_d     = cnt_q;

        active  = aw_pend_q | w_pend_q | b_wait_q;
        ack     = b_wait_q & m_axi.bvalid;
        resp    = m_axi.bresp;
        // AW and W may finish in either order; issued fires on the cycle the last one completes.
        issued  = (aw_pend_q | w_pend_q)
                  & ~(aw_pend_q & ~m_axi.awready)
                  & ~(w_pend_q & ~m_axi.wready);
        timeout = active & (cnt_q == TMO_LAST) & ~ack;

        if (req) begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            b_wait_d  = 1'b0;
            addr_d    = addr;
            data_d    = data;
            cnt_d     = '0;
        end else if (timeout) begin
            // Abandon the transaction outright; the slave is left in an unknown state.
            aw_pend_d = 1'b0;
            w_pend_d  = 1'b0;
            b_wait_d  = 1'b0;
        end else if (active) begin
            if (m_axi.awready) aw_pend_d = 1'b0;
            if (m_axi.wready)  w_pend_d  = 1'b0;
            if (issued)        b_wait_d  = 1'b1;
            if (ack)           b_wait_d  = 1'b0;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            b_wait_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
        end else begin
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            b_wait_q  <= b_wait_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign m_axi.awaddr  = addr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = aw_pend_q;
    assign m_axi.wdata   = data_q;
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.wvalid  = w_pend_q;
    assign m_axi.bready  = b_wait_q;

endmodule

// File: rtl/tpg_cfg_sequencer.sv
// Latches a TPG configuration on start and writes HEIGHT, WIDTH, BG_PATTERN, COLOR_FORMAT, CTRL.
// Latency: busy the cycle after start; PRE_DELAY + 5 writes + GAP_CYCLES before done/error.
// Backpressure: one write outstanding; each write waits on the slave up to TIMEOUT cycles.
// Ports: aclk/aresetn; start + cfg_* in; busy/done/error/err_idx/err_code status out;
//        m_axi AXI4-Lite write master (AR/R not present).
module tpg_cfg_sequencer
    import tpg_cfg_pkg::*;
#(
    parameter logic [AXI_AW-1:0] TPG_BASE   = 12'h000,
    parameter int                PRE_DELAY  = 8,
    parameter int                GAP_CYCLES = 8,
    parameter int                TIMEOUT    = 1024
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    input  logic [15:0] cfg_height,
    input  logic [15:0] cfg_width,
    input  logic [7:0]  cfg_pattern,
    input  logic [7:0]  cfg_format,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  err_idx,
    output logic [1:0]  err_code,
    tpg_cfg_sequencer_if.master m_axi
);

    localparam logic [15:0] DELAY_LAST = 16'(PRE_DELAY - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);

    state_e      state_q,    state_d;
    logic [2:0]  idx_q,      idx_d;
    logic [15:0] cnt_q,      cnt_d;
    cfg_t        cfg_q,      cfg_d;
    logic [2:0]  err_idx_q,  err_idx_d;
    err_e        err_code_q, err_code_d;

    logic              wr_req;
    logic [AXI_AW-1:0] wr_addr;
    logic [AXI_DW-1:0] wr_dat;
    logic              wr_issued;
    logic              wr_ack;
    logic [1:0]        wr_resp;
    logic              wr_tmo;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        cfg_d      = cfg_q;
        err_idx_d  = err_idx_q;
        err_code_d = err_code_q;
        wr_req     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    cfg_d      = {cfg_height, cfg_width, cfg_pattern, cfg_format};
                    err_idx_d  = '0;
                    err_code_d = ERR_NONE;
                    idx_d      = '0;
                    cnt_d      = '0;
                    if (PRE_DELAY == 0) begin
                        state_d = ST_ISSUE;
                        wr_req  = 1'b1;
                    end else begin
                        state_d = ST_DELAY;
                    end
                end
            end
            ST_DELAY: begin
                if (cnt_q == DELAY_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                    wr_req  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_ISSUE: begin
                if (wr_tmo) begin
                    state_d    = ST_ERROR;
                    err_idx_d  = idx_q;
                    err_code_d = ERR_TIMEOUT;
                end else if (wr_issued) begin
                    state_d = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (wr_tmo) begin
                    state_d    = ST_ERROR;
                    err_idx_d  = idx_q;
                    err_code_d = ERR_TIMEOUT;
                end else if (wr_ack) begin
                    if (wr_resp != 2'b00) begin
                        state_d    = ST_ERROR;
                        err_idx_d  = idx_q;
                        err_code_d = ERR_RESP;
                    end else if (idx_q == 3'd3) begin
                        // The TPG needs settling time between format and CTRL writes.
                        if (GAP_CYCLES == 0) begin
                            idx_d   = 3'd4;
                            state_d = ST_ISSUE;
                            wr_req  = 1'b1;
                        end else begin
                            cnt_d   = '0;
                            state_d = ST_GAP;
                        end
                    end else if (idx_q == 3'd4) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_ISSUE;
                        wr_req  = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    idx_d   = 3'd4;
                    state_d = ST_ISSUE;
                    wr_req  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Table lookup uses next-cycle index/config so the request carries the right entry.
        wr_addr = TPG_BASE + wr_offset(idx_d);
        wr_dat  = wr_data(idx_d, cfg_d);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            cfg_q      <= '0;
            err_idx_q  <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            cfg_q      <= cfg_d;
            err_idx_q  <= err_idx_d;
            err_code_q <= err_code_d;
        end
    end

    axil_single_write #(
        .TIMEOUT (TIMEOUT)
    ) u_wr (
        .aclk    (aclk),
        .aresetn (aresetn),
        .req     (wr_req),
        .addr    (wr_addr),
        .data    (wr_dat),
        .issued  (wr_issued),
        .ack     (wr_ack),
        .resp    (wr_resp),
        .timeout (wr_tmo),
        .m_axi   (m_axi)
    );

    assign busy     = (state_q == ST_DELAY) || (state_q == ST_ISSUE) ||
                      (state_q == ST_WAIT_B) || (state_q == ST_GAP);
    assign done     = (state_q == ST_DONE);
    assign error    = (state_q == ST_ERROR);
    assign err_idx  = err_idx_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_tpg_cfg_sequencer.sv
// Bench for tpg_cfg_sequencer: table of slave-timing/config vectors plus timeout, busy-start
// and mid-sequence reset scenarios against a configurable AXI4-Lite slave responder.
// Latency/backpressure: slave readies and B response delayed per vector.
`timescale 1ns/1ps
module tb_tpg_cfg_sequencer;
    import tpg_cfg_pkg::*;

    logic        aclk;
    logic        aresetn;
    logic        start;
    logic [15:0] cfg_height;
    logic [15:0] cfg_width;
    logic [7:0]  cfg_pattern;
    logic [7:0]  cfg_format;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  err_idx;
    logic [1:0]  err_code;

    tpg_cfg_sequencer_if axi ();

    tpg_cfg_sequencer dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .start       (start),
        .cfg_height  (cfg_height),
        .cfg_width   (cfg_width),
        .cfg_pattern (cfg_pattern),
        .cfg_format  (cfg_format),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_idx     (err_idx),
        .err_code    (err_code),
        .m_axi       (axi)
    );

    initial aclk = 1'b0;
    always #12.5 aclk = ~aclk;

    // ---------------- slave responder ----------------
    int          aw_dly = 0, w_dly = 0, b_dly = 0;
    logic        never_b = 1'b0;
    logic        slv_rst = 1'b0;
    int          err_b = -1;
    logic [1:0]  err_resp = 2'b10;

    logic [11:0] aw_log[$];
    logic [31:0] w_log[$];
    int          aw_cyc[$], b_cyc[$], aw_hold[$], w_hold[$];
    int          proto_err = 0;
    int          cyc = 0;

    bit          have_aw, have_w, aw_pend, w_pend;
    int          aw_wait, w_wait, b_wait, aw_run, w_run;
    logic [11:0] aw_prev;
    logic [31:0] w_prev;

    initial begin
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        forever begin
            @(posedge aclk);
            cyc++;
            if (!aresetn || slv_rst) begin
                have_aw = 0; have_w = 0; aw_pend = 0; w_pend = 0;
                aw_wait = 0; w_wait = 0; b_wait = 0; aw_run = 0; w_run = 0;
            end else begin
                // a pending valid must stay up with unchanged payload
                if (aw_pend && (!axi.awvalid || axi.awaddr != aw_prev)) proto_err++;
                if (w_pend && (!axi.wvalid || axi.wdata != w_prev)) proto_err++;
                aw_pend = 0;
                w_pend  = 0;
                if (axi.awvalid) begin
                    if (have_aw) proto_err++;
                    aw_run++;
                    if (axi.awready) begin
                        aw_log.push_back(axi.awaddr);
                        aw_cyc.push_back(cyc);
                        aw_hold.push_back(aw_run);
                        aw_run = 0; aw_wait = 0; have_aw = 1;
                    end else begin
                        aw_pend = 1; aw_prev = axi.awaddr;
                    end
                end
                if (axi.wvalid) begin
                    if (have_w) proto_err++;
                    w_run++;
                    if (axi.wready) begin
                        w_log.push_back(axi.wdata);
                        w_hold.push_back(w_run);
                        w_run = 0; w_wait = 0; have_w = 1;
                    end else begin
                        w_pend = 1; w_prev = axi.wdata;
                    end
                end
                if (axi.bvalid && axi.bready) begin
                    b_cyc.push_back(cyc);
                    have_aw = 0; have_w = 0; b_wait = 0;
                end
            end
            #1;
            if (axi.awvalid && !have_aw) begin
                if (aw_wait >= aw_dly) axi.awready = 1'b1;
                else begin axi.awready = 1'b0; aw_wait++; end
            end else axi.awready = 1'b0;
            if (axi.wvalid && !have_w) begin
                if (w_wait >= w_dly) axi.wready = 1'b1;
                else begin axi.wready = 1'b0; w_wait++; end
            end else axi.wready = 1'b0;
            if (have_aw && have_w && !never_b) begin
                if (b_wait >= b_dly) begin
                    axi.bvalid = 1'b1;
                    axi.bresp  = (b_cyc.size() == err_b) ? err_resp : 2'b00;
                end else begin
                    axi.bvalid = 1'b0; b_wait++;
                end
            end else begin
                axi.bvalid = 1'b0; axi.bresp = 2'b00;
            end
        end
    end

    // ---------------- checking helpers ----------------
    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_writes(input string tag, input int ba, input int bw, input int nexp,
                                input logic [15:0] h, input logic [15:0] w,
                                input logic [7:0] p, input logic [7:0] f);
        logic [11:0] ea [5];
        logic [31:0] ed [5];
        ea = '{12'h010, 12'h018, 12'h020, 12'h040, 12'h000};
        ed = '{{16'h0, h}, {16'h0, w}, {24'h0, p}, {24'h0, f}, 32'h81};
        check({tag, " nAW"}, 32'(aw_log.size() - ba), 32'(nexp));
        check({tag, " nW"}, 32'(w_log.size() - bw), 32'(nexp));
        for (int i = 0; i < nexp; i++) begin
            if (ba + i < aw_log.size() && bw + i < w_log.size()) begin
                check($sformatf("%s awaddr%0d", tag, i), {20'h0, aw_log[ba+i]}, {20'h0, ea[i]});
                check($sformatf("%s wdata%0d", tag, i), w_log[bw+i], ed[i]);
            end
        end
    endtask

    task automatic pulse_start(input logic [15:0] h, input logic [15:0] w,
                               input logic [7:0] p, input logic [7:0] f);
        @(negedge aclk);
        cfg_height = h; cfg_width = w; cfg_pattern = p; cfg_format = f;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        check("busy after start", {31'h0, busy}, 32'h1);
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            @(negedge aclk);
            n++;
        end
        if (busy) begin
            n_chk++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", name, bound);
        end
    endtask

    task automatic wait_aw(input string name, input logic [11:0] addr, input int bound);
        int n;
        n = 0;
        while (!(axi.awvalid && axi.awaddr == addr) && n < bound) begin
            @(negedge aclk);
            n++;
        end
        if (!(axi.awvalid && axi.awaddr == addr)) begin
            n_chk++;
            $display("FAIL %s: no awvalid at 0x%0h within %0d cycles, expected one", name, addr, bound);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          aw_dly, w_dly, b_dly, err_at;
        logic [1:0]  err_resp;
        logic [15:0] h, w;
        logic [7:0]  p, f;
        logic        exp_done, exp_err;
        logic [2:0]  exp_idx;
        logic [1:0]  exp_code;
        int          exp_nwr, exp_awh, exp_wh;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1 ms, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ba, bw, bb, pe, n, gap, snap;

        //          awd wd bd err resp   h       w        p      f     done err idx code  nwr awh wh
        vecs[0] = '{0, 0, 0, 7, 2'b10, 16'd600,  16'd800,  8'd9,   8'd2,   1'b1, 1'b0, 3'd0, 2'b00, 5, 1, 1};
        vecs[1] = '{3, 0, 2, 7, 2'b10, 16'd600,  16'd800,  8'd9,   8'd2,   1'b1, 1'b0, 3'd0, 2'b00, 5, 4, 1};
        vecs[2] = '{0, 0, 0, 2, 2'b10, 16'd600,  16'd800,  8'd9,   8'd2,   1'b0, 1'b1, 3'd2, 2'b01, 3, 1, 1};
        vecs[3] = '{1, 2, 1, 7, 2'b10, 16'd1080, 16'd1920, 8'h55,  8'hAA,  1'b1, 1'b0, 3'd0, 2'b00, 5, 2, 3};
        vecs[4] = '{0, 0, 0, 4, 2'b11, 16'd1,    16'd2,    8'hFF,  8'h00,  1'b0, 1'b1, 3'd4, 2'b01, 5, 1, 1};

        aresetn = 1'b0; start = 1'b0;
        cfg_height = '0; cfg_width = '0; cfg_pattern = '0; cfg_format = '0;
        repeat (3) @(negedge aclk);
        check("reset outputs", {21'h0, busy, done, error, err_idx, err_code, axi.awvalid, axi.wvalid, axi.bready}, 32'h0);
        check("reset awaddr", {20'h0, axi.awaddr}, 32'h0);
        check("reset wdata", axi.wdata, 32'h0);
        aresetn = 1'b1;
        @(negedge aclk);
        check("idle outputs", {27'h0, busy, done, error, axi.awvalid, axi.bready}, 32'h0);
        check("awprot", {29'h0, axi.awprot}, 32'h0);
        check("wstrb", {28'h0, axi.wstrb}, 32'hF);

        for (int v = 0; v < 5; v++) begin
            aw_dly = vecs[v].aw_dly; w_dly = vecs[v].w_dly; b_dly = vecs[v].b_dly;
            err_resp = vecs[v].err_resp;
            err_b = b_cyc.size() + vecs[v].err_at;
            ba = aw_log.size(); bw = w_log.size(); bb = b_cyc.size(); pe = proto_err;
            pulse_start(vecs[v].h, vecs[v].w, vecs[v].p, vecs[v].f);
            wait_idle($sformatf("v%0d", v), 400);
            repeat (3) @(negedge aclk);
            check($sformatf("v%0d busy", v), {31'h0, busy}, 32'h0);
            check($sformatf("v%0d done", v), {31'h0, done}, {31'h0, vecs[v].exp_done});
            check($sformatf("v%0d error", v), {31'h0, error}, {31'h0, vecs[v].exp_err});
            check($sformatf("v%0d err_idx", v), {29'h0, err_idx}, {29'h0, vecs[v].exp_idx});
            check($sformatf("v%0d err_code", v), {30'h0, err_code}, {30'h0, vecs[v].exp_code});
            check_writes($sformatf("v%0d", v), ba, bw, vecs[v].exp_nwr,
                         vecs[v].h, vecs[v].w, vecs[v].p, vecs[v].f);
            if (aw_hold.size() > ba && w_hold.size() > bw) begin
                check($sformatf("v%0d aw hold", v), 32'(aw_hold[ba]), 32'(vecs[v].exp_awh));
                check($sformatf("v%0d w hold", v), 32'(w_hold[bw]), 32'(vecs[v].exp_wh));
            end
            if (vecs[v].exp_nwr == 5 && aw_cyc.size() >= ba + 5 && b_cyc.size() >= bb + 4) begin
                gap = aw_cyc[ba+4] - b_cyc[bb+3];
                n_chk++;
                if (gap >= 8) n_pass++;
                else $display("FAIL v%0d gap: %0d cycles between 4th B and 5th AW, expected >= 8", v, gap);
            end
            check($sformatf("v%0d protocol", v), 32'(proto_err - pe), 32'h0);
        end

        // ---- timeout: slave accepts AW/W but never answers ----
        aw_dly = 0; w_dly = 0; b_dly = 0; err_b = -1; never_b = 1'b1;
        ba = aw_log.size();
        pulse_start(16'd600, 16'd800, 8'd9, 8'd2);
        n = 0;
        while (!axi.awvalid && n < 100) begin @(negedge aclk); n++; end
        check("tmo awvalid seen", {31'h0, axi.awvalid}, 32'h1);
        n = 0;
        while (!error && n < 2000) begin @(negedge aclk); n++; end
        check("tmo cycles", 32'(n), 32'd1024);
        check("tmo err_code", {30'h0, err_code}, 32'h2);
        check("tmo err_idx", {29'h0, err_idx}, 32'h0);
        check("tmo valids", {29'h0, axi.awvalid, axi.wvalid, axi.bready}, 32'h0);
        check("tmo busy", {31'h0, busy}, 32'h0);
        check("tmo nAW", 32'(aw_log.size() - ba), 32'd1);
        @(negedge aclk);
        slv_rst = 1'b1; never_b = 1'b0;
        @(negedge aclk);
        slv_rst = 1'b0;
        ba = aw_log.size(); bw = w_log.size(); pe = proto_err;
        pulse_start(16'd600, 16'd800, 8'd9, 8'd2);
        wait_idle("recover", 400);
        check("recover done", {30'h0, done, error}, 32'h2);
        check("recover err_code", {30'h0, err_code}, 32'h0);
        check_writes("recover", ba, bw, 5, 16'd600, 16'd800, 8'd9, 8'd2);
        check("recover protocol", 32'(proto_err - pe), 32'h0);

        // ---- start while busy is ignored ----
        ba = aw_log.size(); bw = w_log.size();
        pulse_start(16'd600, 16'd800, 8'd9, 8'd2);
        wait_aw("busy start", 12'h018, 100);
        cfg_height = 16'd480; cfg_width = 16'd123;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        wait_idle("busy start", 400);
        repeat (3) @(negedge aclk);
        check("busy start done", {31'h0, done}, 32'h1);
        check_writes("busy start", ba, bw, 5, 16'd600, 16'd800, 8'd9, 8'd2);

        // ---- reset in the middle of write index 3 ----
        pulse_start(16'd600, 16'd800, 8'd9, 8'd2);
        wait_aw("mid reset", 12'h040, 100);
        snap = aw_log.size();
        aresetn = 1'b0;
        @(negedge aclk);
        check("mid reset outputs", {21'h0, busy, done, error, err_idx, err_code, axi.awvalid, axi.wvalid, axi.bready}, 32'h0);
        check("mid reset awaddr", {20'h0, axi.awaddr}, 32'h0);
        check("mid reset wdata", axi.wdata, 32'h0);
        aresetn = 1'b1;
        repeat (20) @(negedge aclk);
        check("mid reset no AW", 32'(aw_log.size() - snap), 32'h0);
        check("mid reset quiet", {30'h0, busy, axi.awvalid}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
